// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_e;

  localparam logic [31:0] RF_RESET_VAL_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: bypass from accepted writes, zero/out-of-range
// masking and scoreboard lookup consistent with the bypass.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NWR      = 2,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                        ready_i,
  input  logic [AW-1:0]               rd_addr_i,
  input  logic [NWR-1:0]              wr_accept_i,
  input  logic [NWR-1:0][AW-1:0]      wr_addr_i,
  input  logic [NWR-1:0][XLEN-1:0]    wr_data_i,
  input  logic [NREGS-1:0][XLEN-1:0]  rf_i,
  input  logic [NREGS-1:0]            busy_i,
  output logic [XLEN-1:0]             rd_data_o,
  output logic                        rd_busy_o
);

  logic            in_range;
  logic            masked;
  logic            byp_hit;
  logic [XLEN-1:0] byp_data;
  logic [AW-1:0]   safe_addr;

  // Select bypass data (highest accepted port wins) or storage, then mask.
  always_comb begin
    in_range  = (32'(rd_addr_i) < NREGS);
    masked    = !ready_i || !in_range || (ZERO_REG && (rd_addr_i == '0));
    safe_addr = in_range ? rd_addr_i : '0;
    byp_hit   = 1'b0;
    byp_data  = '0;
    for (int k = 0; k < NWR; k++) begin
      if (wr_accept_i[k] && (wr_addr_i[k] == rd_addr_i)) begin
        byp_hit  = 1'b1;
        byp_data = wr_data_i[k];
      end
    end
    if (masked) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end else begin
      rd_data_o = byp_hit ? byp_data : rf_i[safe_addr];
      rd_busy_o = busy_i[safe_addr] & ~byp_hit;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with same-cycle bypass, pending-write scoreboard
// and a one-register-per-cycle initialisation sequencer after reset.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned NRD       = 2,
  parameter int unsigned NWR       = 2,
  parameter bit          ZERO_REG  = 1'b1,
  parameter logic [31:0] RESET_VAL = RF_RESET_VAL_DEFAULT,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NRD-1:0][AW-1:0]   rd_addr_i,
  output logic [NRD-1:0][XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]           rd_busy_o,
  input  logic [NWR-1:0]           wr_en_i,
  input  logic [NWR-1:0][AW-1:0]   wr_addr_i,
  input  logic [NWR-1:0][XLEN-1:0] wr_data_i,
  input  logic                     rsv_en_i,
  input  logic [AW-1:0]            rsv_addr_i,
  output logic                     init_done_o
);

  rf_state_e                  state_q, state_d;
  logic [AW-1:0]              cnt_q, cnt_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic [NREGS-1:0][XLEN-1:0] rf_q, rf_d;
  logic [NWR-1:0]             wr_accept;
  logic                       rsv_accept;
  logic                       ready;

  assign ready       = (state_q == RF_READY);
  assign init_done_o = ready;

  // Qualify write and reserve requests: only in READY, in range, not x0.
  always_comb begin
    wr_accept = '0;
    for (int k = 0; k < NWR; k++) begin
      wr_accept[k] = ready && wr_en_i[k] && (32'(wr_addr_i[k]) < NREGS) &&
                     !(ZERO_REG && (wr_addr_i[k] == '0));
    end
    rsv_accept = ready && rsv_en_i && (32'(rsv_addr_i) < NREGS) &&
                 !(ZERO_REG && (rsv_addr_i == '0));
  end

  // Init sequencer: walk the counter through every register, then go ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = RF_READY;
        end
      end
      RF_READY: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Storage next state; ascending loop lets the highest-numbered port win.
  always_comb begin
    rf_d = rf_q;
    if (state_q == RF_INIT) begin
      rf_d[cnt_q] = XLEN'(RESET_VAL);
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_accept[k]) begin
          rf_d[wr_addr_i[k]] = wr_data_i[k];
        end
      end
    end
  end

  // Scoreboard: writes retire pending state, a reserve (applied last) wins.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (wr_accept[k]) begin
        busy_d[wr_addr_i[k]] = 1'b0;
      end
    end
    if (rsv_accept) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Register storage is not reset; the init sequencer fills it.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      rf_q <= rf_d;
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    regfile_read_port #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .ready_i     (ready),
      .rd_addr_i   (rd_addr_i[r]),
      .wr_accept_i (wr_accept),
      .wr_addr_i   (wr_addr_i),
      .wr_data_i   (wr_data_i),
      .rf_i        (rf_q),
      .busy_i      (busy_q),
      .rd_data_o   (rd_data_o[r]),
      .rd_busy_o   (rd_busy_o[r])
    );
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default configuration plus a
// 24-register, 3-read, 1-write configuration sharing clock and reset.
module tb_register_file_mp;

  logic clk;
  logic rst_n;

  // Default instance signals
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0]       rd_busy;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic             rsv_en;
  logic [4:0]       rsv_addr;
  logic             init_done;

  // Small instance signals
  logic [2:0][4:0]  rd_addr24;
  logic [2:0][31:0] rd_data24;
  logic [2:0]       rd_busy24;
  logic [0:0]       wr_en24;
  logic [0:0][4:0]  wr_addr24;
  logic [0:0][31:0] wr_data24;
  logic             rsv_en24;
  logic [4:0]       rsv_addr24;
  logic             init_done24;

  int n_tests;
  int n_fail;
  int first;
  int first24;

  register_file_mp u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_busy_o   (rd_busy),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .rsv_en_i    (rsv_en),
    .rsv_addr_i  (rsv_addr),
    .init_done_o (init_done)
  );

  register_file_mp #(
    .NREGS (24),
    .NRD   (3),
    .NWR   (1)
  ) u_dut24 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_addr_i   (rd_addr24),
    .rd_data_o   (rd_data24),
    .rd_busy_o   (rd_busy24),
    .wr_en_i     (wr_en24),
    .wr_addr_i   (wr_addr24),
    .wr_data_i   (wr_data24),
    .rsv_en_i    (rsv_en24),
    .rsv_addr_i  (rsv_addr24),
    .init_done_o (init_done24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    wr_en24  = '0;
    wr_addr24 = '0;
    wr_data24 = '0;
    rsv_en24 = 1'b0;
    rsv_addr24 = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle_ports();
    rd_addr   = '0;
    rd_addr24 = '0;
    rd_addr[0] = 5'd1;
    rd_addr[1] = 5'd2;

    repeat (3) step();
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_rd_data", 64'(rd_data[0]), 64'd0);
    check("rst_rd_busy", 64'(rd_busy), 64'd0);

    // First release, then restart the sequence after 10 init cycles.
    rst_n = 1'b1;
    repeat (10) step();
    check("init_c10_not_done", 64'(init_done), 64'd0);
    check("init_rd_masked", 64'(rd_data[0]), 64'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // Writes and reserves during init must be ignored.
    wr_en      = 2'b11;
    wr_addr[0] = 5'd3;
    wr_data[0] = 32'h0000_1234;
    wr_addr[1] = 5'd9;
    wr_data[1] = 32'h0000_5678;
    rsv_en     = 1'b1;
    rsv_addr   = 5'd4;
    wr_en24    = 1'b1;
    wr_addr24[0] = 5'd2;
    wr_data24[0] = 32'h0000_ABCD;
    rsv_en24   = 1'b1;
    rsv_addr24 = 5'd5;

    first   = -1;
    first24 = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (init_done && first < 0) begin
        first  = c;
        wr_en  = '0;
        rsv_en = 1'b0;
      end
      if (init_done24 && first24 < 0) begin
        first24  = c;
        wr_en24  = '0;
        rsv_en24 = 1'b0;
      end
    end
    idle_ports();
    check("init_latency_32", 64'(first), 64'd32);
    check("init_latency_24", 64'(first24), 64'd24);

    // Post-init contents.
    rd_addr[0] = 5'd1;
    rd_addr[1] = 5'd31;
    #1;
    check("read_x1_reset", 64'(rd_data[0]), 64'hDEAD_BEEF);
    check("read_x31_reset", 64'(rd_data[1]), 64'hDEAD_BEEF);
    rd_addr[0] = 5'd0;
    rd_addr[1] = 5'd3;
    #1;
    check("read_x0_zero", 64'(rd_data[0]), 64'd0);
    check("init_write_x3_dropped", 64'(rd_data[1]), 64'hDEAD_BEEF);
    rd_addr[0] = 5'd9;
    rd_addr[1] = 5'd4;
    #1;
    check("init_write_x9_dropped", 64'(rd_data[0]), 64'hDEAD_BEEF);
    check("init_rsv_x4_dropped", 64'(rd_busy[1]), 64'd0);
    rd_addr24[0] = 5'd2;
    rd_addr24[1] = 5'd5;
    #1;
    check("init24_write_dropped", 64'(rd_data24[0]), 64'hDEAD_BEEF);
    check("init24_rsv_dropped", 64'(rd_busy24[1]), 64'd0);

    // Two ports write x5 together: port 1 wins in bypass and storage.
    wr_en      = 2'b11;
    wr_addr[0] = 5'd5;
    wr_data[0] = 32'h0000_1111;
    wr_addr[1] = 5'd5;
    wr_data[1] = 32'h0000_2222;
    rd_addr[0] = 5'd5;
    rd_addr[1] = 5'd6;
    #1;
    check("dual_wr_bypass", 64'(rd_data[0]), 64'h2222);
    check("dual_wr_other_reg", 64'(rd_data[1]), 64'hDEAD_BEEF);
    step();
    idle_ports();
    #1;
    check("dual_wr_stored", 64'(rd_data[0]), 64'h2222);

    // Single port 0 write seen through read port 1.
    wr_en      = 2'b01;
    wr_addr[0] = 5'd6;
    wr_data[0] = 32'hA5A5_0001;
    #1;
    check("p0_wr_bypass", 64'(rd_data[1]), 64'hA5A5_0001);
    step();
    idle_ports();
    #1;
    check("p0_wr_stored", 64'(rd_data[1]), 64'hA5A5_0001);

    // x0 is read-only and never busy.
    wr_en      = 2'b10;
    wr_addr[1] = 5'd0;
    wr_data[1] = 32'hFFFF_FFFF;
    rd_addr[0] = 5'd0;
    #1;
    check("x0_wr_bypass_zero", 64'(rd_data[0]), 64'd0);
    step();
    idle_ports();
    rsv_en   = 1'b1;
    rsv_addr = 5'd0;
    #1;
    check("x0_wr_stored_zero", 64'(rd_data[0]), 64'd0);
    step();
    idle_ports();
    #1;
    check("x0_rsv_not_busy", 64'(rd_busy[0]), 64'd0);

    // Scoreboard sequence on x7, with x8 as a neighbour.
    rd_addr[0] = 5'd7;
    rd_addr[1] = 5'd8;
    rsv_en   = 1'b1;
    rsv_addr = 5'd7;
    #1;
    check("sb_rsv_same_cycle", 64'(rd_busy[0]), 64'd0);
    step();
    idle_ports();
    #1;
    check("sb_rsv_busy", 64'(rd_busy[0]), 64'd1);
    check("sb_neighbour_idle", 64'(rd_busy[1]), 64'd0);
    wr_en      = 2'b01;
    wr_addr[0] = 5'd7;
    wr_data[0] = 32'h0000_0077;
    #1;
    check("sb_wr_busy_bypass", 64'(rd_busy[0]), 64'd0);
    check("sb_wr_data_bypass", 64'(rd_data[0]), 64'h77);
    step();
    idle_ports();
    #1;
    check("sb_wr_cleared", 64'(rd_busy[0]), 64'd0);
    check("sb_wr_stored", 64'(rd_data[0]), 64'h77);
    wr_en      = 2'b10;
    wr_addr[1] = 5'd7;
    wr_data[1] = 32'h0000_0088;
    rsv_en     = 1'b1;
    rsv_addr   = 5'd7;
    step();
    idle_ports();
    #1;
    check("sb_rsv_wr_busy", 64'(rd_busy[0]), 64'd1);
    check("sb_rsv_wr_data", 64'(rd_data[0]), 64'h88);

    // Small instance: out-of-range address reads zero and is never written.
    rd_addr24[0] = 5'd30;
    rd_addr24[1] = 5'd6;
    rd_addr24[2] = 5'd14;
    wr_en24      = 1'b1;
    wr_addr24[0] = 5'd30;
    wr_data24[0] = 32'h0000_3030;
    #1;
    check("oor_rd_bypass_zero", 64'(rd_data24[0]), 64'd0);
    step();
    idle_ports();
    #1;
    check("oor_rd_zero", 64'(rd_data24[0]), 64'd0);
    check("oor_no_alias_x6", 64'(rd_data24[1]), 64'hDEAD_BEEF);
    check("oor_no_alias_x14", 64'(rd_data24[2]), 64'hDEAD_BEEF);
    rd_addr24[0] = 5'd23;
    rd_addr24[1] = 5'd22;
    #1;
    check("oor_no_alias_x23", 64'(rd_data24[0]), 64'hDEAD_BEEF);
    wr_en24      = 1'b1;
    wr_addr24[0] = 5'd23;
    wr_data24[0] = 32'h0000_2323;
    #1;
    check("r24_wr_bypass", 64'(rd_data24[0]), 64'h2323);
    step();
    idle_ports();
    #1;
    check("r24_wr_stored", 64'(rd_data24[0]), 64'h2323);
    check("r24_neighbour", 64'(rd_data24[1]), 64'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port integer register file for the core: configurable data width, register count, read-port count and write-port count. Writes are synchronous on the rising edge, with same-cycle write-to-read bypass and a per-register pending-write scoreboard for issue-stage hazard checks. A reset sequencer initialises one register per cycle after reset release. It replaces the fixed 2-read/1-write negedge register file in the decode/writeback path.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; ≥ 2; AW = $clog2(NREGS)
- NRD, 2, number of read ports; ≥ 1
- NWR, 2, number of write ports; ≥ 1
- ZERO_REG, 1, when 1, register 0 is read-only, always reads 0 and is never busy
- RESET_VAL, 32'hDEAD_BEEF, initialisation value, truncated to XLEN
- clk_i  in  1  system clock; all state updates on the rising edge
- rst_ni  in  1  reset; synchronous, active-low
- rd_addr_i  in  NRD×AW  read register numbers
- rd_data_o  out  NRD×XLEN  read data (combinational)
- rd_busy_o  out  NRD  scoreboard state of each read register (combinational)
- wr_en_i  in  NWR  write enables
- wr_addr_i  in  NWR×AW  write register numbers
- wr_data_i  in  NWR×XLEN  write data
- rsv_en_i  in  1  reserve: mark register rsv_addr_i as pending
- rsv_addr_i  in  AW  register to reserve
- init_done_o  out  1  high once initialisation has completed

## Operation
- FSM states are RF_INIT and RF_READY.
- While rst_ni = 0 at an edge, the block does all of the following:
  - enters RF_INIT
  - sets the init counter to 0
  - clears all busy bits
  - sets init_done_o = 0 from the following cycle
- RF_INIT behaviour:
  - Each cycle, RF[counter] ← RESET_VAL and the counter increments.
  - After the edge that writes register NREGS-1, the FSM moves to RF_READY and init_done_o = 1.
  - Write ports and reserve are ignored.
  - rd_data_o = 0 and rd_busy_o = 0.
- Reset asserted mid-initialisation restarts the sequence from register 0.
- RF_READY write rules:
  - Port k writes RF[wr_addr_i[k]] ← wr_data_i[k] when wr_en_i[k] = 1.
  - The write is dropped if the address is 0 with ZERO_REG = 1, or if the address is ≥ NREGS.
  - If several ports write the same register, the highest-numbered port wins.
- Read port r returns data in this priority order:
  - 0 if the address is 0 (with ZERO_REG = 1) or ≥ NREGS
  - otherwise wr_data_i of the highest-numbered enabled port writing that address this cycle (bypass)
  - otherwise RF[rd_addr_i[r]]
- Scoreboard:
  - rsv_en_i sets busy[rsv_addr_i] at the edge.
  - Any accepted write clears busy[wr_addr_i] at the edge.
  - If a reserve and a write target the same register in the same cycle, the reserve wins and busy stays 1 (a new producer is in flight).
  - rd_busy_o[r] = busy[addr] AND NOT (accepted write to addr this cycle), so it is consistent with the bypass.
  - Reserving register 0 (ZERO_REG = 1) or an out-of-range register has no effect.

## Timing
- Initialisation latency: exactly NREGS cycles from the first edge with rst_ni = 1 to init_done_o = 1.
- Writes: visible in RF at the next edge; visible same-cycle on rd_data_o through the bypass.
- Reads and busy: combinational from the address, write ports and state; no registered outputs except init_done_o.
- Reset values: init_done_o = 0, all busy = 0, rd_data_o = 0, rd_busy_o = 0.
- There is no backpressure. Callers must not issue writes before init_done_o = 1; such writes are silently dropped.

## Structure
- Package regfile_pkg contains:
  - rf_state_e enum {RF_INIT, RF_READY}
  - RF_RESET_VAL_DEFAULT constant
- Sub-module regfile_read_port, instantiated NRD times:
  - inputs: one read address, the write-port vectors, the RF array and the busy vector
  - outputs: rd_data and rd_busy, including bypass and zero-register masking
- The top level holds storage, the scoreboard, the write arbitration and the init FSM.

## Test plan
- Reset then release, defaults:
  - init_done_o rises exactly 32 cycles after release.
  - Reads of x1 and x31 then return 32'hDEAD_BEEF; x0 reads 0.
- Reset pulsed at init cycle 10:
  - The counter restarts.
  - init_done_o rises 32 cycles after the second release.
  - No write through the ports lands during init.
- Port 0 writes x5 = 32'h1111 and port 1 writes x5 = 32'h2222 in the same cycle, while read port 0 addresses x5:
  - rd_data_o = 32'h2222 in that same cycle.
  - Next cycle RF[5] = 32'h2222.
- Write to x0 = 32'hFFFF_FFFF: x0 still reads 0. Reserve x0: rd_busy_o stays 0.
- Scoreboard sequence:
  - Reserve x7: next cycle rd_busy_o = 1.
  - Write x7: rd_busy_o = 0 in the same cycle, and stays 0 after.
  - Simultaneous reserve and write of x7: rd_busy_o = 1 the following cycle, with the data updated.
- NREGS = 24, NRD = 3, NWR = 1:
  - Init takes 24 cycles.
  - Read of address 30 returns 0.
  - Write to address 30 is dropped and no register changes.
